// File: rtl/nrd8.sv
// nrd8: fully pipelined 8-bit / 7-bit unsigned non-restoring divider, one quotient bit per stage.
// Latency 8 edges (capture into S1 through the output register). No backpressure; accepts one pair every clock.
// Optional NRD8_VALID_EN adds in_valid/out_valid tracking alongside the data.
module nrd8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic [6:0] b,
  output logic [7:0] quo,
  output logic [7:0] rem
`ifdef NRD8_VALID_EN
  ,
  input  logic       in_valid,
  output logic       out_valid
`endif
);

  // One non-restoring iteration: shift in the next dividend bit, then add or subtract b by the old sign.
  function automatic logic signed [9:0] nr_step(input logic signed [9:0] p,
                                                input logic               abit,
                                                input logic [6:0]         d);
    logic signed [9:0] sh;
    logic signed [9:0] dv;
    sh = {p[8:0], abit};
    dv = {3'b000, d};
    return p[9] ? (sh + dv) : (sh - dv);
  endfunction

  // Stage k (1..7) registers. r_aq is a shared shift register: the unconsumed dividend
  // bits sit at the top, the resolved quotient bits fill in from the bottom.
  logic signed [9:0] r_p  [1:7];
  logic        [7:0] r_aq [1:7];
  logic        [6:0] r_b  [1:7];
  logic        [7:1] r_live;

  logic signed [9:0] w_p_in  [0:7];
  logic signed [9:0] w_p_nx  [0:7];
  logic        [7:0] w_aq_in [0:7];
  logic        [7:0] w_aq_nx [0:7];
  logic        [6:0] w_b_in  [0:7];
  logic signed [9:0] w_rem_fix;

  always_comb begin
    w_p_in[0]  = '0;
    w_aq_in[0] = a;
    w_b_in[0]  = b;
    for (int k = 1; k < 8; k++) begin
      w_p_in[k]  = r_p[k];
      w_aq_in[k] = r_aq[k];
      w_b_in[k]  = r_b[k];
    end
    for (int k = 0; k < 8; k++) begin
      w_p_nx[k]  = nr_step(w_p_in[k], w_aq_in[k][7], w_b_in[k]);
      w_aq_nx[k] = {w_aq_in[k][6:0], ~w_p_nx[k][9]};
    end
    // Final correction; with b=0 the remainder degenerates to a and is masked to 7 bits.
    w_rem_fix = w_p_nx[7][9] ? (w_p_nx[7] + $signed({3'b000, w_b_in[7]})) : w_p_nx[7];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k < 8; k++) begin
        r_p[k]  <= '0;
        r_aq[k] <= '0;
        r_b[k]  <= '0;
      end
      r_live <= '0;
      quo    <= '0;
      rem    <= '0;
    end else begin
      for (int k = 1; k < 8; k++) begin
        r_p[k]  <= w_p_nx[k-1];
        r_aq[k] <= w_aq_nx[k-1];
        r_b[k]  <= w_b_in[k-1];
      end
      // r_live keeps the outputs at 0 until the first post-reset operand arrives.
      r_live <= {r_live[6:1], 1'b1};
      quo    <= r_live[7] ? w_aq_nx[7] : 8'h00;
      rem    <= r_live[7] ? 8'(w_rem_fix & 10'h07F) : 8'h00;
    end
  end

`ifdef NRD8_VALID_EN
  logic [7:1] r_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v       <= '0;
      out_valid <= 1'b0;
    end else begin
      r_v       <= {r_v[6:1], in_valid};
      out_valid <= r_v[7];
    end
  end
`endif

endmodule

// File: tb/tb_nrd8.sv
// Scoreboard bench for nrd8: expected results queued at issue, compared when due at the output.
module tb_nrd8;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] a     = '0;
  logic [6:0] b     = '0;
  logic [7:0] quo;
  logic [7:0] rem;
`ifdef NRD8_VALID_EN
  logic       in_valid = 1'b0;
  logic       out_valid;
`endif

  typedef struct {
    int due;
    int q;
    int r;
    bit v;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  nrd8 dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .quo      (quo),
    .rem      (rem)
`ifdef NRD8_VALID_EN
    ,
    .in_valid (in_valid),
    .out_valid(out_valid)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("quo", {24'd0, quo}, e.q);
      chk("rem", {24'd0, rem}, e.r);
`ifdef NRD8_VALID_EN
      chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
`endif
    end else begin
      chk("quo_idle", {24'd0, quo}, 0);
      chk("rem_idle", {24'd0, rem}, 0);
`ifdef NRD8_VALID_EN
      chk("out_valid_idle", {31'd0, out_valid}, 0);
`endif
    end
  endtask

  // Compare what is due this cycle, then drive the next pair (captured at the next rising edge).
  task automatic issue(input int ai, input int bi, input bit vi);
    exp_t e;
    @(negedge clk);
    check_out();
    a = 8'(ai);
    b = 7'(bi);
`ifdef NRD8_VALID_EN
    in_valid = vi;
`endif
    if (reset) begin
      e.due = cyc + 8;
      e.q   = (bi == 0) ? 255 : ai / bi;
      e.r   = (bi == 0) ? (ai & 127) : ai % bi;
      e.v   = vi;
      sb.push_back(e);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  int stream_a[11] = '{50, 40, 40, 118, 218, 255, 255, 0, 6, 100, 200};
  int stream_b[11] = '{ 4,  3,  2,  20,  24,   1, 127, 5, 7,   0,   0};

  initial begin
    for (int i = 0; i < 4; i++) issue($urandom_range(0, 255), $urandom_range(0, 127), 1'b1);
    release_reset();

    for (int i = 0; i < 11; i++) issue(stream_a[i], stream_b[i], 1'b1);
    issue(77, 5, 1'b1);
    issue(78, 5, 1'b0);
    issue(79, 5, 1'b1);
    for (int i = 0; i < 20; i++)
      issue($urandom_range(0, 255), $urandom_range(0, 127), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 10; i++) issue(0, 1, 1'b1);

    // Asynchronous reset between edges with the pipeline full of work.
    for (int i = 0; i < 3; i++) issue(200 + i, 3, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("quo_async_rst", {24'd0, quo}, 0);
    chk("rem_async_rst", {24'd0, rem}, 0);
`ifdef NRD8_VALID_EN
    chk("out_valid_async_rst", {31'd0, out_valid}, 0);
`endif
    sb.delete();
    for (int i = 0; i < 3; i++) issue($urandom_range(0, 255), $urandom_range(0, 127), 1'b1);
    release_reset();

    for (int i = 0; i < 12; i++) issue($urandom_range(0, 255), $urandom_range(0, 127), 1'b1);
    for (int i = 0; i < 9; i++) issue(255, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
